// File: rtl/seg7_bus_decoder.sv
// Receive-side decoder for a scanned 4-digit active-low 7-segment bus.
// Recovers the displayed hex digits and publishes complete frames.
module seg7_bus_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [10:0] disp_in,
  output logic [15:0] value_out,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        err_pattern,
  output logic        err_multi_anode,
  output logic        stale
);

  localparam logic [15:0] StMax    = 16'(STABLE_CYCLES);
  localparam logic [15:0] StEvalAt = 16'(STABLE_CYCLES - 2);
  localparam logic [23:0] ToMax    = 24'(TIMEOUT_CYCLES);
  localparam logic [23:0] ToLast   = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StSettle, StEval, StHold} state_e;

  logic [10:0] r_sync1, r_sync2, r_prev;
  state_e      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [23:0] r_tcnt, w_tcnt_nxt;
  logic [15:0] r_shadow, w_shadow_nxt;
  logic [3:0]  r_seen, w_seen_nxt;
  logic [15:0] r_value, w_value_nxt;
  logic [3:0]  r_dv, w_dv_nxt;
  logic        r_frame, w_frame_nxt;
  logic        r_err_pat, w_err_pat_nxt;
  logic        r_err_multi, w_err_multi_nxt;
  logic        r_stale, w_stale_nxt;

  logic        w_change, w_eval, w_blank, w_one, w_accept;
  logic [1:0]  w_idx;
  logic [3:0]  w_sel;
  logic [4:0]  w_glyph;

  function automatic logic [4:0] f_glyph(input logic [6:0] seg);
    case (seg)
      7'b0000001: f_glyph = {1'b1, 4'h0};
      7'b1001111: f_glyph = {1'b1, 4'h1};
      7'b0010010: f_glyph = {1'b1, 4'h2};
      7'b0000110: f_glyph = {1'b1, 4'h3};
      7'b1001100: f_glyph = {1'b1, 4'h4};
      7'b0100100: f_glyph = {1'b1, 4'h5};
      7'b0100000: f_glyph = {1'b1, 4'h6};
      7'b0001111: f_glyph = {1'b1, 4'h7};
      7'b0000000: f_glyph = {1'b1, 4'h8};
      7'b0000100: f_glyph = {1'b1, 4'h9};
      7'b0001000: f_glyph = {1'b1, 4'hA};
      7'b1100000: f_glyph = {1'b1, 4'hB};
      7'b0110001: f_glyph = {1'b1, 4'hC};
      7'b1000010: f_glyph = {1'b1, 4'hD};
      7'b0110000: f_glyph = {1'b1, 4'hE};
      7'b0111000: f_glyph = {1'b1, 4'hF};
      default:    f_glyph = 5'b0_0000;
    endcase
  endfunction

  assign w_change = (r_sync2 != r_prev);
  assign w_glyph  = f_glyph(r_sync2[6:0]);

  // Stability counter and capture FSM; any change of S restarts settling.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_eval      = 1'b0;
    if (w_change) begin
      w_state_nxt = StSettle;
      w_cnt_nxt   = 16'd0;
    end else begin
      if (r_cnt != StMax) w_cnt_nxt = r_cnt + 16'd1;
      case (r_state)
        StSettle: if (r_cnt == StEvalAt) w_state_nxt = StEval;
        StEval: begin
          w_state_nxt = StHold;
          w_eval      = 1'b1;
        end
        StHold:   w_state_nxt = StHold;
        default:  w_state_nxt = StSettle;
      endcase
    end
  end

  always_comb begin
    w_blank = 1'b0;
    w_one   = 1'b0;
    w_idx   = 2'd0;
    case (r_sync2[10:7])
      4'b1111: w_blank = 1'b1;
      4'b1110: begin w_one = 1'b1; w_idx = 2'd0; end
      4'b1101: begin w_one = 1'b1; w_idx = 2'd1; end
      4'b1011: begin w_one = 1'b1; w_idx = 2'd2; end
      4'b0111: begin w_one = 1'b1; w_idx = 2'd3; end
      default: w_one = 1'b0;
    endcase
  end

  assign w_sel           = 4'b0001 << w_idx;
  assign w_accept        = w_eval && w_one && w_glyph[4];
  assign w_err_pat_nxt   = w_eval && w_one && !w_glyph[4];
  assign w_err_multi_nxt = w_eval && !w_one && !w_blank;

  // Capture, frame assembly and timeout; an accepted digit always beats the timeout.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_seen_nxt   = r_seen;
    w_value_nxt  = r_value;
    w_dv_nxt     = r_dv;
    w_frame_nxt  = 1'b0;
    w_tcnt_nxt   = r_tcnt;
    w_stale_nxt  = r_stale;
    if (w_accept) begin
      w_shadow_nxt[{w_idx, 2'b00} +: 4] = w_glyph[3:0];
      w_seen_nxt  = r_seen | w_sel;
      w_dv_nxt    = r_dv | w_sel;
      w_tcnt_nxt  = 24'd0;
      w_stale_nxt = 1'b0;
      if (w_seen_nxt == 4'b1111) begin
        w_value_nxt = w_shadow_nxt;
        w_frame_nxt = 1'b1;
        w_seen_nxt  = 4'b0000;
      end
    end else begin
      if (r_tcnt != ToMax) w_tcnt_nxt = r_tcnt + 24'd1;
      if (r_tcnt == ToLast) begin
        w_stale_nxt = 1'b1;
        w_dv_nxt    = 4'b0000;
        w_seen_nxt  = 4'b0000;
      end
    end
  end

  // Synchronizer resets to the blank word so reset never looks like a multi-anode hit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1     <= 11'h7FF;
      r_sync2     <= 11'h7FF;
      r_prev      <= 11'h7FF;
      r_state     <= StSettle;
      r_cnt       <= 16'd0;
      r_tcnt      <= 24'd0;
      r_shadow    <= 16'd0;
      r_seen      <= 4'd0;
      r_value     <= 16'd0;
      r_dv        <= 4'd0;
      r_frame     <= 1'b0;
      r_err_pat   <= 1'b0;
      r_err_multi <= 1'b0;
      r_stale     <= 1'b1;
    end else begin
      r_sync1     <= disp_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_seen      <= w_seen_nxt;
      r_value     <= w_value_nxt;
      r_dv        <= w_dv_nxt;
      r_frame     <= w_frame_nxt;
      r_err_pat   <= w_err_pat_nxt;
      r_err_multi <= w_err_multi_nxt;
      r_stale     <= w_stale_nxt;
    end
  end

  assign value_out       = r_value;
  assign digit_valid     = r_dv;
  assign frame_valid     = r_frame;
  assign err_pattern     = r_err_pat;
  assign err_multi_anode = r_err_multi;
  assign stale           = r_stale;

endmodule

// File: tb/tb_seg7_bus_decoder.sv
// Directed self-checking bench for seg7_bus_decoder (STABLE_CYCLES=16, TIMEOUT_CYCLES=1000).
module tb_seg7_bus_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] disp;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic        frame_valid, err_pattern, err_multi_anode, stale;

  int n_checks = 0;
  int n_errors = 0;
  int n_frame  = 0;
  int n_pat    = 0;
  int n_multi  = 0;
  int f0, p0, m0;

  always #5 clk = ~clk;

  seg7_bus_decoder #(
    .STABLE_CYCLES (16),
    .TIMEOUT_CYCLES(1000)
  ) u_dut (
    .CLK            (clk),
    .RST            (rst),
    .disp_in        (disp),
    .value_out      (value_out),
    .digit_valid    (digit_valid),
    .frame_valid    (frame_valid),
    .err_pattern    (err_pattern),
    .err_multi_anode(err_multi_anode),
    .stale          (stale)
  );

  // Count high cycles of each pulse output, sampled just after the active edge.
  always @(posedge clk) begin
    #2;
    if (frame_valid)     n_frame++;
    if (err_pattern)     n_pat++;
    if (err_multi_anode) n_multi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [10:0] w, input int n);
    disp = w;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    disp = 11'h7FF;
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value_out), 32'h0);
    chk("rst_dv", 32'(digit_valid), 32'h0);
    chk("rst_frame", 32'(frame_valid), 32'h0);
    chk("rst_errs", 32'({err_pattern, err_multi_anode}), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    rst = 1'b0;
    hold(11'h7FF, 30);

    // Latency: capture lands at edge k+18 after first sample at edge k.
    f0   = n_frame;
    disp = {4'b0111, 7'b1001111};
    repeat (18) @(negedge clk);
    chk("lat_dv_before", 32'(digit_valid), 32'h0);
    chk("lat_stale_before", 32'(stale), 32'h1);
    @(negedge clk);
    chk("lat_dv_after", 32'(digit_valid), 32'h8);
    chk("lat_stale_after", 32'(stale), 32'h0);
    repeat (81) @(negedge clk);
    hold({4'b1011, 7'b0010010}, 100);
    hold({4'b1101, 7'b0000110}, 100);
    hold({4'b1110, 7'b1001100}, 100);
    chk("scan_frames", 32'(n_frame - f0), 32'd1);
    chk("scan_value", 32'(value_out), 32'h1234);
    chk("scan_dv", 32'(digit_valid), 32'hF);
    chk("scan_stale", 32'(stale), 32'h0);

    // Reversed anode order.
    f0 = n_frame;
    hold({4'b1110, 7'b1001111}, 100);
    hold({4'b1101, 7'b0010010}, 100);
    hold({4'b1011, 7'b0000110}, 100);
    hold({4'b0111, 7'b1001100}, 100);
    chk("rev_frames", 32'(n_frame - f0), 32'd1);
    chk("rev_value", 32'(value_out), 32'h4321);

    // Error pulses.
    f0 = n_frame;
    m0 = n_multi;
    p0 = n_pat;
    hold({4'b0011, 7'b0000001}, 50);
    chk("multi_pulses", 32'(n_multi - m0), 32'd1);
    chk("multi_no_pat", 32'(n_pat - p0), 32'd0);
    hold({4'b1110, 7'b1111110}, 50);
    chk("pat_pulses", 32'(n_pat - p0), 32'd1);
    chk("pat_no_multi", 32'(n_multi - m0), 32'd1);
    chk("err_no_frame", 32'(n_frame - f0), 32'd0);
    chk("err_value_kept", 32'(value_out), 32'h4321);
    chk("err_stale", 32'(stale), 32'h0);

    // Timeout.
    hold(11'h7FF, 1005);
    chk("to_stale", 32'(stale), 32'h1);
    chk("to_dv", 32'(digit_valid), 32'h0);
    chk("to_value_kept", 32'(value_out), 32'h4321);

    // Short glitch is never evaluated; the following legal digit clears stale.
    hold({4'b1011, 7'b0000000}, 10);
    chk("glitch_dv", 32'(digit_valid), 32'h0);
    chk("glitch_stale", 32'(stale), 32'h1);
    hold({4'b1011, 7'b1001111}, 100);
    chk("recover_dv", 32'(digit_valid), 32'h4);
    chk("recover_stale", 32'(stale), 32'h0);
    f0 = n_frame;
    hold({4'b0111, 7'b0100100}, 100);
    hold({4'b1101, 7'b0100000}, 100);
    hold({4'b1110, 7'b0001111}, 100);
    chk("recover_frames", 32'(n_frame - f0), 32'd1);
    chk("recover_value", 32'(value_out), 32'h5167);

    // Reset mid-frame discards captured digits 3 and 2.
    hold({4'b0111, 7'b0000100}, 100);
    hold({4'b1011, 7'b0001000}, 40);
    rst = 1'b1;
    #1;
    chk("mid_rst_value", 32'(value_out), 32'h0);
    chk("mid_rst_dv", 32'(digit_valid), 32'h0);
    chk("mid_rst_stale", 32'(stale), 32'h1);
    chk("mid_rst_frame", 32'(frame_valid), 32'h0);
    disp = 11'h7FF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(11'h7FF, 20);
    chk("post_rst_dv", 32'(digit_valid), 32'h0);
    chk("post_rst_stale", 32'(stale), 32'h1);
    f0 = n_frame;
    hold({4'b1101, 7'b0000110}, 100);
    hold({4'b1110, 7'b1001100}, 100);
    hold({4'b0111, 7'b1001111}, 100);
    hold({4'b1011, 7'b0010010}, 100);
    chk("post_rst_frames", 32'(n_frame - f0), 32'd1);
    chk("post_rst_value", 32'(value_out), 32'h1234);
    chk("post_rst_full_dv", 32'(digit_valid), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
